gpio_bus_arb: RTL and testbench

- Two-master arbiter and sequencer in front of the GPIO register port (we/addr/wdata in, registered rdata out).
- Master 0 is the core load/store path; master 1 is the debug/UART-debug master.
- Serialises accesses and rejects non-GPIO register offsets.
- Returns read data or write acknowledgement to the winning master, matching the GPIO's one-cycle registered read latency.

---
 rtl/gpio_bus_arb_pkg.sv | 19 +
 rtl/gpio_bus_arb_if.sv | 46 ++++
 rtl/gpio_bus_arb_rr_arb2.sv | 44 ++++
 rtl/gpio_bus_arb.sv | 148 ++++++++++++++
 tb/tb_gpio_bus_arb.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_bus_arb_pkg.sv
// Shared definitions for the two-master GPIO bus arbiter: register offsets,
// sequencer state encoding and the register-offset decode helper.
package gpio_bus_arb_pkg;

    localparam logic [3:0] GPIO_CTRL = 4'h0;
    localparam logic [3:0] GPIO_DATA = 4'h1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Only the low nibble selects a register; upper address bits are passed through undecoded
    function automatic logic offset_ok(input logic [31:0] addr, input int unsigned num_regs);
        return ({28'd0, addr[3:0]} < num_regs);
    endfunction

endpackage

// File: rtl/gpio_bus_arb_if.sv
// Bundle of both master command/response ports and the GPIO register port.
// The slave modport is the arbiter's view; the master modport is the masters' and GPIO's view.
interface gpio_bus_arb_if;

    logic        m0_req_i;
    logic        m0_we_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_data_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic        m0_rerr_o;
    logic [31:0] m0_rdata_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_data_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic        m1_rerr_o;
    logic [31:0] m1_rdata_o;

    logic        s_we_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_data_o;
    logic [31:0] s_data_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_data_i,
        output m0_gnt_o, m0_rvalid_o, m0_rerr_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_data_i,
        output m1_gnt_o, m1_rvalid_o, m1_rerr_o, m1_rdata_o,
        output s_we_o, s_addr_o, s_data_o,
        input  s_data_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_data_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rerr_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_data_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rerr_o, m1_rdata_o,
        input  s_we_o, s_addr_o, s_data_o,
        output s_data_i
    );

endinterface

// File: rtl/gpio_bus_arb_rr_arb2.sv
// Two-input grant picker: fixed priority to input 0, or alternation based on
// the last winner. Grant is one-hot and only non-zero while en is high.
module gpio_bus_arb_rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_gnt_r;

    // Pick a winner; a lone requester always wins
    always_comb begin
        gnt = 2'b00;
        if (!en) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            if (FIXED_PRIO || last_gnt_r) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else begin
            gnt = req;
        end
    end

    // Remember the last winner; reset favours master 0 on the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_r <= 1'b1;
        end else if (gnt[1]) begin
            last_gnt_r <= 1'b1;
        end else if (gnt[0]) begin
            last_gnt_r <= 1'b0;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

endmodule

// File: rtl/gpio_bus_arb.sv
// Two-master arbiter and sequencer in front of the GPIO register port:
// IDLE arbitrates, ACCESS drives the GPIO, RESP returns its registered read data.
module gpio_bus_arb
    import gpio_bus_arb_pkg::*;
#(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned NUM_REGS   = 32'd2
) (
    input logic           clk,
    input logic           rst_n,
    gpio_bus_arb_if.slave bus
);

    arb_state_e  state_r;
    logic        winner_r;
    logic        ok_r;
    logic        gnt0_r, gnt1_r;
    logic        rvalid0_r, rvalid1_r;
    logic        rerr0_r, rerr1_r;
    logic [31:0] rdata0_r, rdata1_r;
    logic        s_we_r;
    logic [31:0] s_addr_r, s_data_r;

    logic        arb_en_s;
    logic [1:0]  pick_s;
    logic        win_we_s;
    logic [31:0] win_addr_s, win_data_s;
    logic        win_ok_s;
    logic [31:0] resp_data_s;

    assign arb_en_s = (state_r == IDLE);

    gpio_bus_arb_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en_s),
        .req   ({bus.m1_req_i, bus.m0_req_i}),
        .gnt   (pick_s)
    );

    // Route the winning master's command fields
    always_comb begin
        win_we_s   = bus.m0_we_i;
        win_addr_s = bus.m0_addr_i;
        win_data_s = bus.m0_data_i;
        if (pick_s[1]) begin
            win_we_s   = bus.m1_we_i;
            win_addr_s = bus.m1_addr_i;
            win_data_s = bus.m1_data_i;
        end else begin
            win_we_s   = bus.m0_we_i;
            win_addr_s = bus.m0_addr_i;
            win_data_s = bus.m0_data_i;
        end
        win_ok_s = offset_ok(win_addr_s, NUM_REGS);
    end

    // GPIO read data arrives in RESP, one cycle after the address, so it is forwarded directly
    assign resp_data_s = ok_r ? bus.s_data_i : 32'd0;

    // Sequencer: capture command in IDLE, drive GPIO in ACCESS, respond in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            winner_r  <= 1'b0;
            ok_r      <= 1'b0;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rerr0_r   <= 1'b0;
            rerr1_r   <= 1'b0;
            rdata0_r  <= 32'd0;
            rdata1_r  <= 32'd0;
            s_we_r    <= 1'b0;
            s_addr_r  <= 32'd0;
            s_data_r  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_s != 2'b00) begin
                        winner_r <= pick_s[1];
                        ok_r     <= win_ok_s;
                        gnt0_r   <= pick_s[0];
                        gnt1_r   <= pick_s[1];
                        s_we_r   <= win_we_s & win_ok_s;
                        s_addr_r <= win_addr_s;
                        s_data_r <= win_data_s;
                        state_r  <= ACCESS;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                ACCESS: begin
                    gnt0_r    <= 1'b0;
                    gnt1_r    <= 1'b0;
                    s_we_r    <= 1'b0;
                    rvalid0_r <= ~winner_r;
                    rvalid1_r <= winner_r;
                    rerr0_r   <= ~winner_r & ~ok_r;
                    rerr1_r   <= winner_r & ~ok_r;
                    state_r   <= RESP;
                end
                RESP: begin
                    // Latch the forwarded data so rdata holds between pulses
                    if (rvalid0_r) begin
                        rdata0_r <= resp_data_s;
                    end else begin
                        rdata0_r <= rdata0_r;
                    end
                    if (rvalid1_r) begin
                        rdata1_r <= resp_data_s;
                    end else begin
                        rdata1_r <= rdata1_r;
                    end
                    rvalid0_r <= 1'b0;
                    rvalid1_r <= 1'b0;
                    rerr0_r   <= 1'b0;
                    rerr1_r   <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    gnt0_r    <= 1'b0;
                    gnt1_r    <= 1'b0;
                    rvalid0_r <= 1'b0;
                    rvalid1_r <= 1'b0;
                    rerr0_r   <= 1'b0;
                    rerr1_r   <= 1'b0;
                    s_we_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.m0_gnt_o    = gnt0_r;
    assign bus.m1_gnt_o    = gnt1_r;
    assign bus.m0_rvalid_o = rvalid0_r;
    assign bus.m1_rvalid_o = rvalid1_r;
    assign bus.m0_rerr_o   = rerr0_r;
    assign bus.m1_rerr_o   = rerr1_r;
    assign bus.m0_rdata_o  = rvalid0_r ? resp_data_s : rdata0_r;
    assign bus.m1_rdata_o  = rvalid1_r ? resp_data_s : rdata1_r;
    assign bus.s_we_o      = s_we_r;
    assign bus.s_addr_o    = s_addr_r;
    assign bus.s_data_o    = s_data_r;

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Scoreboard bench for gpio_bus_arb: one round-robin and one fixed-priority
// instance, each behind a small GPIO register model with registered read data.
module tb_gpio_bus_arb;
    import gpio_bus_arb_pkg::*;

    typedef struct {int m; int gcyc; int rcyc; logic [31:0] rdata; logic rerr;} exp_t;
    typedef struct {int m; int cyc;} gnt_ev_t;
    typedef struct {int m; int cyc; logic [31:0] rdata; logic rerr;} rsp_ev_t;
    typedef struct {int cyc; logic [31:0] addr; logic [31:0] data;} we_ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    exp_t    exp_q[$];
    gnt_ev_t gnt_q[$];
    gnt_ev_t gnt1_q[$];
    rsp_ev_t rsp_q[$];
    we_ev_t  we_q[$];

    logic [31:0] g0_regs [2];
    logic [31:0] g1_regs [2];

    gpio_bus_arb_if b0();
    gpio_bus_arb_if b1();

    gpio_bus_arb #(.FIXED_PRIO(1'b0), .NUM_REGS(32'd2)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(b0));
    gpio_bus_arb #(.FIXED_PRIO(1'b1), .NUM_REGS(32'd2)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(b1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // GPIO models: write on we, registered read data echoes a write
    always @(posedge clk) begin
        if (b0.s_we_o && b0.s_addr_o[3:0] < 4'd2) g0_regs[b0.s_addr_o[0]] <= b0.s_data_o;
        b0.s_data_i <= b0.s_we_o ? b0.s_data_o :
                       (b0.s_addr_o[3:0] < 4'd2 ? g0_regs[b0.s_addr_o[0]] : 32'd0);
        if (b1.s_we_o && b1.s_addr_o[3:0] < 4'd2) g1_regs[b1.s_addr_o[0]] <= b1.s_data_o;
        b1.s_data_i <= b1.s_we_o ? b1.s_data_o :
                       (b1.s_addr_o[3:0] < 4'd2 ? g1_regs[b1.s_addr_o[0]] : 32'd0);
    end

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (b0.m0_gnt_o) gnt_q.push_back('{m: 0, cyc: cyc});
        if (b0.m1_gnt_o) gnt_q.push_back('{m: 1, cyc: cyc});
        if (b0.m0_rvalid_o) rsp_q.push_back('{m: 0, cyc: cyc, rdata: b0.m0_rdata_o, rerr: b0.m0_rerr_o});
        if (b0.m1_rvalid_o) rsp_q.push_back('{m: 1, cyc: cyc, rdata: b0.m1_rdata_o, rerr: b0.m1_rerr_o});
        if (b0.s_we_o) we_q.push_back('{cyc: cyc, addr: b0.s_addr_o, data: b0.s_data_o});
        if (b1.m0_gnt_o) gnt1_q.push_back('{m: 0, cyc: cyc});
        if (b1.m1_gnt_o) gnt1_q.push_back('{m: 1, cyc: cyc});
    end

    task automatic idle_inputs();
        b0.m0_req_i = 1'b0; b0.m0_we_i = 1'b0; b0.m0_addr_i = 32'd0; b0.m0_data_i = 32'd0;
        b0.m1_req_i = 1'b0; b0.m1_we_i = 1'b0; b0.m1_addr_i = 32'd0; b0.m1_data_i = 32'd0;
        b1.m0_req_i = 1'b0; b1.m0_we_i = 1'b0; b1.m0_addr_i = 32'd0; b1.m0_data_i = 32'd0;
        b1.m1_req_i = 1'b0; b1.m1_we_i = 1'b0; b1.m1_addr_i = 32'd0; b1.m1_data_i = 32'd0;
    endtask

    task automatic clear_queues();
        exp_q.delete(); gnt_q.delete(); gnt1_q.delete(); rsp_q.delete(); we_q.delete();
    endtask

    // Single transaction on the round-robin instance; returns the cycle req was driven
    task automatic txn0(input int m, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, output int c0);
        @(negedge clk);
        c0 = cyc;
        if (m == 0) begin
            b0.m0_we_i = we; b0.m0_addr_i = addr; b0.m0_data_i = data; b0.m0_req_i = 1'b1;
        end else begin
            b0.m1_we_i = we; b0.m1_addr_i = addr; b0.m1_data_i = data; b0.m1_req_i = 1'b1;
        end
        @(negedge clk);
        b0.m0_req_i = 1'b0;
        b0.m1_req_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({b0.m0_gnt_o, b0.m1_gnt_o, b0.m0_rvalid_o, b0.m1_rvalid_o, b0.m0_rerr_o, b0.m1_rerr_o, b0.s_we_o} !== 7'd0)
            $display("FAIL reset_ctl_rr: got %b required 0", {b0.m0_gnt_o, b0.m1_gnt_o, b0.m0_rvalid_o,
                     b0.m1_rvalid_o, b0.m0_rerr_o, b0.m1_rerr_o, b0.s_we_o});
        else n_pass++;
        n_checks++;
        if ({b1.m0_gnt_o, b1.m1_gnt_o, b1.m0_rvalid_o, b1.m1_rvalid_o, b1.m0_rerr_o, b1.m1_rerr_o, b1.s_we_o} !== 7'd0)
            $display("FAIL reset_ctl_fp: got %b required 0", {b1.m0_gnt_o, b1.m1_gnt_o, b1.m0_rvalid_o,
                     b1.m1_rvalid_o, b1.m0_rerr_o, b1.m1_rerr_o, b1.s_we_o});
        else n_pass++;
        n_checks++;
        if ({b0.m0_rdata_o, b0.m1_rdata_o} !== 64'd0)
            $display("FAIL reset_rdata: got %h %h required 0", b0.m0_rdata_o, b0.m1_rdata_o);
        else n_pass++;
        n_checks++;
        if ({b0.s_addr_o, b0.s_data_o} !== 64'd0)
            $display("FAIL reset_sport: got addr %h data %h required 0", b0.s_addr_o, b0.s_data_o);
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ((gnt_q.size() + rsp_q.size() + we_q.size()) != 0)
            $display("FAIL idle_no_req: got %0d events required 0", gnt_q.size() + rsp_q.size() + we_q.size());
        else n_pass++;
    endtask

    task automatic test_write();
        int c0;
        we_ev_t w;
        clear_queues();
        txn0(0, 1'b1, {28'd0, GPIO_CTRL}, 32'h0000_0005, c0);
        exp_q.push_back('{m: 0, gcyc: c0 + 1, rcyc: c0 + 2, rdata: 32'h5, rerr: 1'b0});
        n_checks++;
        if (we_q.size() != 1) $display("FAIL write_we_count: got %0d required 1", we_q.size());
        else begin
            w = we_q.pop_front();
            if (w.cyc != c0 + 1 || w.addr !== 32'd0 || w.data !== 32'h5)
                $display("FAIL write_sport: got @%0d %h/%h required @%0d 0/5", w.cyc, w.addr, w.data, c0 + 1);
            else n_pass++;
        end
        txn0(0, 1'b1, {28'd0, GPIO_DATA}, 32'h0000_00A3, c0);
        exp_q.push_back('{m: 0, gcyc: c0 + 1, rcyc: c0 + 2, rdata: 32'hA3, rerr: 1'b0});
        while (exp_q.size() != 0) begin
            exp_t e; gnt_ev_t g; rsp_ev_t r;
            e = exp_q.pop_front();
            if (gnt_q.size() != 0) g = gnt_q.pop_front(); else g = '{m: -1, cyc: -1};
            if (rsp_q.size() != 0) r = rsp_q.pop_front(); else r = '{m: -1, cyc: -1, rdata: {32{1'bx}}, rerr: 1'bx};
            n_checks++;
            if (g.m != e.m || g.cyc != e.gcyc) $display("FAIL write_gnt: got m%0d@%0d required m%0d@%0d", g.m, g.cyc, e.m, e.gcyc);
            else n_pass++;
            n_checks++;
            if (r.m != e.m || r.cyc != e.rcyc) $display("FAIL write_rvalid: got m%0d@%0d required m%0d@%0d", r.m, r.cyc, e.m, e.rcyc);
            else n_pass++;
            n_checks++;
            if (r.rdata !== e.rdata || r.rerr !== e.rerr)
                $display("FAIL write_resp: got %h/%b required %h/%b", r.rdata, r.rerr, e.rdata, e.rerr);
            else n_pass++;
        end
    endtask

    task automatic test_read();
        int c0;
        clear_queues();
        txn0(1, 1'b0, {28'd0, GPIO_DATA}, 32'h0, c0);
        exp_q.push_back('{m: 1, gcyc: c0 + 1, rcyc: c0 + 2, rdata: 32'hA3, rerr: 1'b0});
        n_checks++;
        if (we_q.size() != 0) $display("FAIL read_no_we: got %0d writes required 0", we_q.size());
        else n_pass++;
        while (exp_q.size() != 0) begin
            exp_t e; gnt_ev_t g; rsp_ev_t r;
            e = exp_q.pop_front();
            if (gnt_q.size() != 0) g = gnt_q.pop_front(); else g = '{m: -1, cyc: -1};
            if (rsp_q.size() != 0) r = rsp_q.pop_front(); else r = '{m: -1, cyc: -1, rdata: {32{1'bx}}, rerr: 1'bx};
            n_checks++;
            if (g.m != e.m || g.cyc != e.gcyc) $display("FAIL read_gnt: got m%0d@%0d required m%0d@%0d", g.m, g.cyc, e.m, e.gcyc);
            else n_pass++;
            n_checks++;
            if (r.m != e.m || r.cyc != e.rcyc || r.rdata !== e.rdata || r.rerr !== e.rerr)
                $display("FAIL read_resp: got m%0d@%0d %h/%b required m%0d@%0d %h/%b",
                         r.m, r.cyc, r.rdata, r.rerr, e.m, e.rcyc, e.rdata, e.rerr);
            else n_pass++;
        end
        n_checks++;
        if (b0.m1_rdata_o !== 32'hA3) $display("FAIL read_hold: got %h required a3", b0.m1_rdata_o);
        else n_pass++;
    endtask

    task automatic test_bad_offset();
        int c0;
        clear_queues();
        txn0(0, 1'b1, 32'h0000_0003, 32'hDEAD_BEEF, c0);
        exp_q.push_back('{m: 0, gcyc: c0 + 1, rcyc: c0 + 2, rdata: 32'h0, rerr: 1'b1});
        txn0(1, 1'b0, {28'd0, GPIO_CTRL}, 32'h0, c0);
        exp_q.push_back('{m: 1, gcyc: c0 + 1, rcyc: c0 + 2, rdata: 32'h5, rerr: 1'b0});
        txn0(1, 1'b0, {28'd0, GPIO_DATA}, 32'h0, c0);
        exp_q.push_back('{m: 1, gcyc: c0 + 1, rcyc: c0 + 2, rdata: 32'hA3, rerr: 1'b0});
        n_checks++;
        if (we_q.size() != 0) $display("FAIL bad_no_we: got %0d writes required 0", we_q.size());
        else n_pass++;
        while (exp_q.size() != 0) begin
            exp_t e; rsp_ev_t r;
            e = exp_q.pop_front();
            if (rsp_q.size() != 0) r = rsp_q.pop_front(); else r = '{m: -1, cyc: -1, rdata: {32{1'bx}}, rerr: 1'bx};
            n_checks++;
            if (r.m != e.m || r.cyc != e.rcyc || r.rdata !== e.rdata || r.rerr !== e.rerr)
                $display("FAIL bad_offset_resp: got m%0d@%0d %h/%b required m%0d@%0d %h/%b",
                         r.m, r.cyc, r.rdata, r.rerr, e.m, e.rcyc, e.rdata, e.rerr);
            else n_pass++;
        end
    endtask

    task automatic test_rr_alternate();
        int c0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        clear_queues();
        @(negedge clk);
        c0 = cyc;
        b0.m0_we_i = 1'b0; b0.m0_addr_i = {28'd0, GPIO_CTRL};
        b0.m1_we_i = 1'b0; b0.m1_addr_i = {28'd0, GPIO_DATA};
        b0.m0_req_i = 1'b1; b0.m1_req_i = 1'b1;
        repeat (10) @(negedge clk);
        b0.m0_req_i = 1'b0; b0.m1_req_i = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{m: k % 2, gcyc: c0 + 1 + 3 * k, rcyc: c0 + 2 + 3 * k,
                              rdata: (k % 2 == 0) ? 32'h5 : 32'hA3, rerr: 1'b0});
        while (exp_q.size() != 0) begin
            exp_t e; gnt_ev_t g; rsp_ev_t r;
            e = exp_q.pop_front();
            if (gnt_q.size() != 0) g = gnt_q.pop_front(); else g = '{m: -1, cyc: -1};
            if (rsp_q.size() != 0) r = rsp_q.pop_front(); else r = '{m: -1, cyc: -1, rdata: {32{1'bx}}, rerr: 1'bx};
            n_checks++;
            if (g.m != e.m || g.cyc != e.gcyc) $display("FAIL rr_gnt: got m%0d@%0d required m%0d@%0d", g.m, g.cyc, e.m, e.gcyc);
            else n_pass++;
            n_checks++;
            if (r.m != e.m || r.cyc != e.rcyc || r.rdata !== e.rdata)
                $display("FAIL rr_resp: got m%0d@%0d %h required m%0d@%0d %h", r.m, r.cyc, r.rdata, e.m, e.rcyc, e.rdata);
            else n_pass++;
        end
        n_checks++;
        if (gnt_q.size() != 0) $display("FAIL rr_extra_gnt: got %0d extra required 0", gnt_q.size());
        else n_pass++;
    endtask

    task automatic test_fixed_prio();
        int c0;
        clear_queues();
        @(negedge clk);
        c0 = cyc;
        b1.m0_we_i = 1'b0; b1.m0_addr_i = 32'd0;
        b1.m1_we_i = 1'b0; b1.m1_addr_i = 32'd0;
        b1.m0_req_i = 1'b1; b1.m1_req_i = 1'b1;
        repeat (10) @(negedge clk);
        b1.m0_req_i = 1'b0; b1.m1_req_i = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            gnt_ev_t g;
            if (gnt1_q.size() != 0) g = gnt1_q.pop_front(); else g = '{m: -1, cyc: -1};
            n_checks++;
            if (g.m != 0 || g.cyc != c0 + 1 + 3 * k)
                $display("FAIL fixed_gnt: got m%0d@%0d required m0@%0d", g.m, g.cyc, c0 + 1 + 3 * k);
            else n_pass++;
        end
        n_checks++;
        if (gnt1_q.size() != 0) $display("FAIL fixed_extra_gnt: got %0d extra required 0", gnt1_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_queues();
        @(negedge clk);
        b0.m0_we_i = 1'b1; b0.m0_addr_i = {28'd0, GPIO_CTRL}; b0.m0_data_i = 32'h0000_0077;
        b0.m0_req_i = 1'b1;
        @(negedge clk);
        b0.m0_req_i = 1'b0;
        n_checks++;
        if (b0.s_we_o !== 1'b1) $display("FAIL mid_access_we: got %b required 1", b0.s_we_o);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({b0.s_we_o, b0.m0_gnt_o} !== 2'b00) $display("FAIL mid_async_drop: got %b required 00", {b0.s_we_o, b0.m0_gnt_o});
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rsp_q.size() != 0) $display("FAIL mid_no_rvalid: got %0d responses required 0", rsp_q.size());
        else n_pass++;
        clear_queues();
        txn0(1, 1'b0, {28'd0, GPIO_CTRL}, 32'h0, c0);
        exp_q.push_back('{m: 1, gcyc: c0 + 1, rcyc: c0 + 2, rdata: 32'h5, rerr: 1'b0});
        while (exp_q.size() != 0) begin
            exp_t e; rsp_ev_t r;
            e = exp_q.pop_front();
            if (rsp_q.size() != 0) r = rsp_q.pop_front(); else r = '{m: -1, cyc: -1, rdata: {32{1'bx}}, rerr: 1'bx};
            n_checks++;
            if (r.m != e.m || r.cyc != e.rcyc || r.rdata !== e.rdata || r.rerr !== e.rerr)
                $display("FAIL mid_recover: got m%0d@%0d %h/%b required m%0d@%0d %h/%b",
                         r.m, r.cyc, r.rdata, r.rerr, e.m, e.rcyc, e.rdata, e.rerr);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        clear_queues();
        @(negedge clk);
        c0 = cyc;
        b0.m1_we_i = 1'b0; b0.m1_addr_i = {28'd0, GPIO_CTRL}; b0.m1_req_i = 1'b1;
        @(negedge clk);
        b0.m1_addr_i = {28'd0, GPIO_DATA};
        repeat (3) @(negedge clk);
        b0.m1_req_i = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back('{m: 1, gcyc: c0 + 1, rcyc: c0 + 2, rdata: 32'h5, rerr: 1'b0});
        exp_q.push_back('{m: 1, gcyc: c0 + 4, rcyc: c0 + 5, rdata: 32'hA3, rerr: 1'b0});
        while (exp_q.size() != 0) begin
            exp_t e; gnt_ev_t g; rsp_ev_t r;
            e = exp_q.pop_front();
            if (gnt_q.size() != 0) g = gnt_q.pop_front(); else g = '{m: -1, cyc: -1};
            if (rsp_q.size() != 0) r = rsp_q.pop_front(); else r = '{m: -1, cyc: -1, rdata: {32{1'bx}}, rerr: 1'bx};
            n_checks++;
            if (g.m != e.m || g.cyc != e.gcyc) $display("FAIL b2b_gnt: got m%0d@%0d required m%0d@%0d", g.m, g.cyc, e.m, e.gcyc);
            else n_pass++;
            n_checks++;
            if (r.m != e.m || r.cyc != e.rcyc || r.rdata !== e.rdata)
                $display("FAIL b2b_resp: got m%0d@%0d %h required m%0d@%0d %h", r.m, r.cyc, r.rdata, e.m, e.rcyc, e.rdata);
            else n_pass++;
        end
        n_checks++;
        if (gnt_q.size() != 0) $display("FAIL b2b_extra_gnt: got %0d extra required 0", gnt_q.size());
        else n_pass++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write();
        test_read();
        test_bad_offset();
        test_rr_alternate();
        test_fixed_prio();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
